// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issues RS entries to two multer units, tracks their latency and arbitrates the CDB.
module mul_issue_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic [2:0] rs_valid,
  input  logic [2:0] rs_ready,
  input  logic [8:0] rs_fun3,
  input  logic [8:0] rs_des,
  output logic [1:0] unit_start,
  output logic [3:0] unit_sel,
  output logic [5:0] unit_fun3,
  output logic [1:0] unit_busy,
  output logic [2:0] rs_release,
  output logic       cdb_valid,
  output logic       cdb_unit,
  output logic [2:0] cdb_tag
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2;
  logic [1:0] st [2];
  logic [4:0] cnt [2];
  logic [2:0] tag [2];
  logic [2:0] f3 [2];
  logic [1:0] sel [2];
  logic [2:0] issued, elig, rem;
  logic [1:0] a, b, idle, done, gnt, waited;
  logic a_ok, b_ok;
  assign elig = rs_valid & rs_ready & ~issued & {3{~rst}};
  assign a = elig[0] ? 2'd0 : elig[1] ? 2'd1 : 2'd2;
  assign a_ok = |elig;
  assign rem = elig & ~(3'b001 << a);
  assign b = rem[0] ? 2'd0 : rem[1] ? 2'd1 : 2'd2;
  assign b_ok = |rem;
  assign idle = {st[1] == IDLE, st[0] == IDLE};
  assign done = {st[1] == DONE, st[0] == DONE} & {2{~rst}};
  // Unit 1 takes the second eligible entry only when unit 0 is also taking one.
  assign sel[0] = a;
  assign sel[1] = idle[0] ? b : a;
  assign unit_start = {idle[1] & (idle[0] ? b_ok : a_ok), idle[0] & a_ok};
  assign unit_sel = {unit_start[1] ? sel[1] : 2'd0, unit_start[0] ? sel[0] : 2'd0};
  assign unit_fun3 = {unit_start[1] ? rs_fun3[3*sel[1] +: 3] : 3'd0,
                      unit_start[0] ? rs_fun3[3*sel[0] +: 3] : 3'd0};
  assign rs_release = (unit_start[0] ? 3'b001 << sel[0] : 3'b000) |
                      (unit_start[1] ? 3'b001 << sel[1] : 3'b000);
  assign unit_busy = ~idle & {2{~rst}};
  // A unit that already waited a cycle in DONE beats one that just arrived; ties go to unit 0.
  assign gnt[1] = done[1] & (~done[0] | (waited[1] & ~waited[0]));
  assign gnt[0] = done[0] & ~gnt[1];
  assign cdb_valid = |gnt;
  assign cdb_unit = gnt[1];
  assign cdb_tag = gnt[1] ? tag[1] : gnt[0] ? tag[0] : 3'd0;
  always_ff @(posedge clk1) begin
    if (rst) begin
      issued <= '0;
      waited <= '0;
      for (int k = 0; k < 2; k++) begin
        st[k] <= IDLE;
        cnt[k] <= '0;
        tag[k] <= '0;
        f3[k] <= '0;
      end
    end else begin
      issued <= (issued | rs_release) & rs_valid;
      waited <= done & ~gnt;
      for (int k = 0; k < 2; k++)
        case (st[k])
          IDLE: if (unit_start[k]) begin
            st[k] <= EXEC;
            tag[k] <= rs_des[3*sel[k] +: 3];
            f3[k] <= rs_fun3[3*sel[k] +: 3];
            cnt[k] <= rs_fun3[3*sel[k] +: 3] == 3'd1 ? 5'(DIV_LAT - 1) : 5'(MUL_LAT - 1);
          end
          EXEC: if (cnt[k] == 5'd0) st[k] <= DONE; else cnt[k] <= cnt[k] - 5'd1;
          DONE: if (gnt[k]) st[k] <= IDLE;
          default: st[k] <= IDLE;
        endcase
    end
  end
  logic unused_f3;
  assign unused_f3 = ^{f3[0], f3[1]};
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: table vectors, directed multi-cycle scenarios and a randomized run against a timestamp model.
module tb_mul_issue_ctrl;
  localparam int MUL = 4, DIV = 16;
  logic clk1 = 0, rst = 1;
  logic [2:0] rs_valid = 0, rs_ready = 0;
  logic [8:0] rs_fun3 = 0, rs_des = 0;
  logic [1:0] unit_start, unit_busy;
  logic [3:0] unit_sel;
  logic [5:0] unit_fun3;
  logic [2:0] rs_release, cdb_tag;
  logic cdb_valid, cdb_unit;
  int checks = 0, fails = 0, cyc = 0;
  always #5 clk1 = ~clk1;
  mul_issue_ctrl #(.MUL_LAT(MUL), .DIV_LAT(DIV)) dut (
    .clk1(clk1), .rst(rst), .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_fun3(rs_fun3),
    .rs_des(rs_des), .unit_start(unit_start), .unit_sel(unit_sel), .unit_fun3(unit_fun3),
    .unit_busy(unit_busy), .rs_release(rs_release), .cdb_valid(cdb_valid),
    .cdb_unit(cdb_unit), .cdb_tag(cdb_tag)
  );
  // Model: each unit is busy from its start until the cycle after its result is granted;
  // its result is ready at start+LAT+1, and the earliest-ready result wins the CDB.
  bit mbusy [2];
  int mfin [2];
  logic [2:0] mtag [2];
  logic [2:0] missued = 0;
  typedef struct { int c; int u; int t; } ev_t;
  ev_t log[$];
  int rel_cnt [3];
  int rel_cyc [3];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic cycle();
    logic [1:0] es, eb;
    logic [3:0] esel;
    logic [5:0] ef;
    logic [2:0] erel, etag;
    logic ev, eu;
    int el[$];
    int iu[$];
    int w;
    @(negedge clk1);
    es = 0; eb = 0; esel = 0; ef = 0; erel = 0; etag = 0; ev = 0; eu = 0; w = -1;
    if (!rst) begin
      for (int i = 0; i < 3; i++) if (rs_valid[i] && rs_ready[i] && !missued[i]) el.push_back(i);
      for (int k = 0; k < 2; k++) if (!mbusy[k]) iu.push_back(k); else eb[k] = 1;
      for (int k = 0; k < 2; k++)
        if (mbusy[k] && mfin[k] <= cyc && (w < 0 || mfin[k] < mfin[w])) w = k;
      if (w >= 0) begin ev = 1; eu = w[0]; etag = mtag[w]; end
      for (int n = 0; n < el.size() && n < iu.size(); n++) begin
        es[iu[n]] = 1;
        esel[2*iu[n] +: 2] = 2'(el[n]);
        ef[3*iu[n] +: 3] = rs_fun3[3*el[n] +: 3];
        erel[el[n]] = 1;
      end
    end
    chk("outputs", {unit_start, unit_sel, unit_fun3, unit_busy, rs_release, cdb_valid, cdb_unit, cdb_tag},
        {es, esel, ef, eb, erel, ev, eu, etag});
    if (cdb_valid) log.push_back('{cyc, int'(cdb_unit), int'(cdb_tag)});
    for (int i = 0; i < 3; i++) if (rs_release[i]) begin rel_cnt[i]++; rel_cyc[i] = cyc; end
    if (rst) begin
      mbusy[0] = 0; mbusy[1] = 0; missued = 0;
    end else begin
      if (w >= 0) mbusy[w] = 0;
      for (int n = 0; n < el.size() && n < iu.size(); n++) begin
        mbusy[iu[n]] = 1;
        mfin[iu[n]] = cyc + 1 + (rs_fun3[3*el[n] +: 3] == 3'd1 ? DIV : MUL);
        mtag[iu[n]] = rs_des[3*el[n] +: 3];
      end
      missued = (missued | erel) & rs_valid;
    end
    @(posedge clk1);
    cyc++;
    #1;
  endtask
  task automatic reset_all();
    rst = 1; rs_valid = 0; rs_ready = 0; rs_fun3 = 0; rs_des = 0;
    cycle();
    rst = 0;
    log.delete();
    for (int i = 0; i < 3; i++) begin rel_cnt[i] = 0; rel_cyc[i] = -1; end
  endtask
  task automatic chk_ev(string name, int idx, int c, int u, int t);
    if (idx < log.size()) begin
      chk({name, "_cyc"}, log[idx].c, c);
      chk({name, "_unit"}, log[idx].u, u);
      chk({name, "_tag"}, log[idx].t, t);
    end else chk({name, "_missing"}, log.size(), idx + 1);
  endtask
  typedef struct {
    logic [2:0] v, r;
    logic [8:0] f, d;
    logic [1:0] es;
    logic [3:0] sel;
    logic [5:0] ef;
    logic [2:0] rel;
  } vec_t;
  vec_t tbl [7];
  int t;
  initial begin
    tbl[0] = '{3'b010, 3'b010, 9'o000, 9'o050, 2'b01, 4'b0001, 6'o00, 3'b010};
    tbl[1] = '{3'b101, 3'b101, 9'o001, 9'o603, 2'b11, 4'b1000, 6'o01, 3'b101};
    tbl[2] = '{3'b111, 3'b011, 9'o222, 9'o321, 2'b11, 4'b0100, 6'o22, 3'b011};
    tbl[3] = '{3'b111, 3'b000, 9'o111, 9'o777, 2'b00, 4'b0000, 6'o00, 3'b000};
    tbl[4] = '{3'b000, 3'b111, 9'o111, 9'o777, 2'b00, 4'b0000, 6'o00, 3'b000};
    tbl[5] = '{3'b100, 3'b100, 9'o100, 9'o400, 2'b01, 4'b0010, 6'o01, 3'b100};
    tbl[6] = '{3'b110, 3'b111, 9'o310, 9'o560, 2'b11, 4'b1001, 6'o31, 3'b110};
    @(posedge clk1); #1;
    chk("reset_outputs", {unit_start, unit_sel, unit_fun3, unit_busy, rs_release, cdb_valid, cdb_unit, cdb_tag}, 0);
    rs_valid = 3'b111; rs_ready = 3'b111; #1;
    chk("no_issue_in_reset", {unit_start, rs_release}, 0);
    for (int n = 0; n < 7; n++) begin
      reset_all();
      rs_valid = tbl[n].v; rs_ready = tbl[n].r; rs_fun3 = tbl[n].f; rs_des = tbl[n].d;
      #1;
      chk($sformatf("vec%0d_start", n), unit_start, tbl[n].es);
      chk($sformatf("vec%0d_sel", n), unit_sel, tbl[n].sel);
      chk($sformatf("vec%0d_fun3", n), unit_fun3, tbl[n].ef);
      chk($sformatf("vec%0d_release", n), rs_release, tbl[n].rel);
      cycle();
    end
    // single multiply
    reset_all();
    rs_valid = 3'b010; rs_ready = 3'b010; rs_des = 9'o050; t = cyc;
    cycle(); rs_valid = 0;
    repeat (10) cycle();
    chk("mul_count", log.size(), 1);
    chk_ev("mul", 0, t + 5, 0, 5);
    // dual issue, divide on unit 0 and multiply on unit 1
    reset_all();
    rs_valid = 3'b101; rs_ready = 3'b101; rs_fun3 = 9'o001; rs_des = 9'o603; t = cyc;
    cycle(); rs_valid = 0;
    repeat (20) cycle();
    chk("dual_count", log.size(), 2);
    chk_ev("dual_mul", 0, t + 5, 1, 6);
    chk_ev("dual_div", 1, t + 17, 0, 3);
    // two multiplies collide on the CDB
    reset_all();
    rs_valid = 3'b011; rs_ready = 3'b011; rs_des = 9'o021; t = cyc;
    cycle(); rs_valid = 0;
    repeat (10) cycle();
    chk("coll_count", log.size(), 2);
    chk_ev("coll_u0", 0, t + 5, 0, 1);
    chk_ev("coll_u1", 1, t + 6, 1, 2);
    // back-pressure: three divides, two units
    reset_all();
    rs_valid = 3'b111; rs_ready = 3'b111; rs_fun3 = 9'o111; rs_des = 9'o764; t = cyc;
    repeat (40) cycle();
    rs_valid = 0;
    cycle();
    for (int i = 0; i < 3; i++) chk($sformatf("bp_rel%0d", i), rel_cnt[i], 1);
    chk("bp_third_issue", rel_cyc[2], t + 18);
    chk("bp_count", log.size(), 3);
    chk_ev("bp_e0", 0, t + 17, 0, 4);
    chk_ev("bp_e1", 1, t + 18, 1, 6);
    chk_ev("bp_e2", 2, t + 35, 0, 7);
    // reset in the middle of a divide
    reset_all();
    rs_valid = 3'b001; rs_ready = 3'b001; rs_fun3 = 9'o001; rs_des = 9'o002; t = cyc;
    cycle(); rs_valid = 0;
    repeat (7) cycle();
    rst = 1; cycle(); rst = 0; #1;
    chk("rst_busy", unit_busy, 0);
    repeat (25) cycle();
    chk("rst_no_cdb", log.size(), 0);
    rs_valid = 3'b010; rs_ready = 3'b010; rs_fun3 = 0; rs_des = 9'o030; t = cyc;
    cycle(); rs_valid = 0;
    repeat (8) cycle();
    chk("rst_fresh_count", log.size(), 1);
    chk_ev("rst_fresh", 0, t + 5, 0, 3);
    // entry waits on operands
    reset_all();
    rs_valid = 3'b001; rs_ready = 0; rs_des = 9'o004;
    repeat (20) cycle();
    chk("nr_no_release", rel_cnt[0], 0);
    rs_ready = 3'b001; t = cyc;
    cycle();
    chk("nr_issue_cycle", rel_cyc[0], t);
    rs_valid = 0;
    repeat (8) cycle();
    chk_ev("nr_done", 0, t + 5, 0, 4);
    // randomized traffic with an upstream that refills and frees entries
    reset_all();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 3; i++)
        if (!rs_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            rs_valid[i] = 1;
            rs_ready[i] = 1'($urandom_range(0, 1));
            rs_fun3[3*i +: 3] = 3'($urandom_range(0, 3));
            rs_des[3*i +: 3] = 3'($urandom);
          end
        end else if (missued[i]) begin
          if ($urandom_range(0, 1) == 0) begin rs_valid[i] = 0; rs_ready[i] = 0; end
        end else if (!rs_ready[i] && $urandom_range(0, 2) == 0) rs_ready[i] = 1;
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4, SHALL set the multiply execute latency in cycles (legal range 1..31).
REQ-002 Parameter DIV_LAT, default 16, SHALL set the divide execute latency in cycles (legal range 1..31).
REQ-003 clk1  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rs_valid  in  3  entry i of the multiply reservation station is occupied.
REQ-006 rs_ready  in  3  both operands of entry i are ready.
REQ-007 rs_fun3  in  9  fun3 of entry i on bits [3i+2:3i]; value 1 means divide, any other value means multiply.
REQ-008 rs_des  in  9  ROB destination tag of entry i on bits [3i+2:3i].
REQ-009 unit_start  out  2  one-cycle start pulse to multer unit k.
REQ-010 unit_sel  out  4  RS index issued to unit k on bits [2k+1:2k]; valid only with unit_start[k].
REQ-011 unit_fun3  out  6  fun3 forwarded to unit k on bits [3k+2:3k]; valid only with unit_start[k].
REQ-012 unit_busy  out  2  unit k is not IDLE.
REQ-013 rs_release  out  3  one-cycle pulse when entry i is issued; upstream frees the entry.
REQ-014 cdb_valid  out  1  a unit result is broadcast this cycle.
REQ-015 cdb_unit  out  1  index of the broadcasting unit.
REQ-016 cdb_tag  out  3  ROB tag of the broadcast result.

Function
REQ-017 Each unit k SHALL have a three-state FSM: IDLE, EXEC, DONE.
REQ-018 IDLE->EXEC on unit_start[k]; the latency counter SHALL load LAT-1 (DIV_LAT if fun3==1, else MUL_LAT), and the tag and fun3 SHALL be latched.
REQ-019 In EXEC the counter SHALL decrement each cycle; EXEC->DONE in the cycle after the counter reads 0.
REQ-020 In DONE the unit SHALL request the CDB; DONE->IDLE in the cycle after it is granted.
REQ-021 Issue SHALL occur in a start cycle t; the uncontended broadcast SHALL occur in cycle t+LAT+1, i.e. t+5 for a multiply and t+17 for a divide at the default parameters.
REQ-022 An entry SHALL be eligible when rs_valid & rs_ready & ~issued[i].
REQ-023 The issued[i] bit SHALL set on release and clear when rs_valid[i] is low.
REQ-024 Up to two issues per cycle SHALL be made: the lowest-index eligible entry to the lowest-index IDLE unit, and the next eligible entry to the other IDLE unit.
REQ-025 Only units IDLE at the start of the cycle SHALL be issued to; a unit leaving DONE becomes issuable one cycle later.
REQ-026 CDB arbitration SHALL allow at most one grant per cycle.
REQ-027 When both units are in DONE, the unit that entered DONE earlier SHALL win; on a tie, unit 0 SHALL win; the loser SHALL stay in DONE without a lost or duplicated broadcast.
REQ-028 cdb_valid, cdb_unit and cdb_tag SHALL be combinational from the DONE state and the arbiter, and the tag SHALL be the one latched at start.
REQ-029 rs_release[i] SHALL equal unit_start for the issuing entry in the same cycle; no entry SHALL be released twice.
REQ-030 No issue SHALL occur while both units are busy; eligible entries SHALL wait without loss.

Reset
REQ-031 When rst is high at a clock edge, both FSMs SHALL go to IDLE, counters, tags and issued bits SHALL clear, and any operation in flight SHALL be discarded without broadcast.
REQ-032 During and after reset, all outputs SHALL be 0 (unit_start, unit_sel, unit_fun3, unit_busy, rs_release, cdb_valid, cdb_unit, cdb_tag) until new activity.
REQ-033 While rst is high, the block SHALL make no issue regardless of the RS inputs.

Verification
REQ-034 Single mul: entry 1 valid+ready, fun3=0, des=5 at t -> unit_start=01, unit_sel[1:0]=1, rs_release=010 at t; cdb_valid with cdb_unit=0, cdb_tag=5 at t+5 only.
REQ-035 Dual issue: entries 0 and 2 eligible with fun3=1 and 0 at t -> unit0 gets entry 0 (div), unit1 gets entry 2 (mul); unit1 broadcasts at t+5 and unit0 broadcasts at t+17.
REQ-036 CDB collision: two muls issued the same cycle t -> unit0 broadcasts at t+5, unit1 at t+6, and each tag appears exactly once.
REQ-037 Full back-pressure: 3 entries eligible with both units busy on divides -> the third entry is issued in the cycle after the first unit returns to IDLE, and rs_release pulses once per entry.
REQ-038 Reset mid-divide: rst asserted at t+8 of a divide -> no cdb_valid follows, unit_busy=00 at t+9, and a fresh mul issued afterwards completes at its start+5.
REQ-039 Non-ready entry: rs_valid=1 and rs_ready=0 for 20 cycles -> no issue; rs_ready rises -> the entry issues in that same cycle.
